// File: rtl/vram_arbiter_if.sv
// rtl/vram_arbiter_if.sv - bus bundle between the vram arbiter, its clients and the VRAM
//
// Groups the pixel-write stream, the swap/blank controls, the scanout read
// port, the VRAM primitive port and the status outputs.
//   slave  : the arbiter's view (drives WrReady, RdData/RdValid, Mem*, status)
//   master : the environment's view (decoder, timing block, scanout, RAM)
interface vram_arbiter_if #(
    parameter int AddrWidth = 18
);
    logic                 WrValid;
    logic                 WrReady;
    logic [15:0]          WrX;
    logic [15:0]          WrY;
    logic [7:0]           WrData;
    logic                 SwapReq;
    logic                 VBlank;
    logic                 RdReq;
    logic [AddrWidth-1:0] RdAddr;
    logic [7:0]           RdData;
    logic                 RdValid;
    logic [AddrWidth-1:0] MemAddr;
    logic [7:0]           MemWData;
    logic                 MemWe;
    logic [7:0]           MemRData;
    logic                 FrontBuf;
    logic                 SwapPending;
    logic [7:0]           DropCount;

    modport slave (
        input  WrValid, WrX, WrY, WrData, SwapReq, VBlank, RdReq, RdAddr, MemRData,
        output WrReady, RdData, RdValid, MemAddr, MemWData, MemWe,
               FrontBuf, SwapPending, DropCount
    );

    modport master (
        output WrValid, WrX, WrY, WrData, SwapReq, VBlank, RdReq, RdAddr, MemRData,
        input  WrReady, RdData, RdValid, MemAddr, MemWData, MemWe,
               FrontBuf, SwapPending, DropCount
    );
endinterface

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - single-port VRAM arbiter with write FIFO and double-buffer swap
//
// Shares one synchronous single-port VRAM between the scanout reader (strict
// priority, fixed 3-cycle latency) and the pixel-write stream (X/Y translated
// to a linear offset at push time, buffered in a small FIFO, based into the
// back buffer when issued). BufSwap is executed during vertical blank once
// every write queued before the request has been issued.
//
// Ports:
//   Clk, ResetN : clock, synchronous active-low reset
//   bus (slave) : WrValid/WrReady/WrX/WrY/WrData  pixel-write stream
//                 SwapReq, VBlank                  swap request, blanking
//                 RdReq/RdAddr/RdData/RdValid      scanout read port
//                 MemAddr/MemWData/MemWe/MemRData  VRAM primitive
//                 FrontBuf, SwapPending, DropCount status
//
// Optional feature: define VRAM_CLEAR_EN to fill the new back buffer with
// ClearColor after every swap; writes are held off until the fill completes.
module vram_arbiter #(
    parameter int         HRes       = 320,
    parameter int         VRes       = 240,
    parameter int         AddrWidth  = 18,
    parameter int         FifoDepth  = 4,
    parameter logic [7:0] ClearColor = 8'h00
) (
    input logic           Clk,
    input logic           ResetN,
    vram_arbiter_if.slave bus
);
    localparam int PtrW = $clog2(FifoDepth);
    localparam logic [AddrWidth-1:0] FRAME_SIZE = AddrWidth'(HRes * VRes);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PEND  = 2'd1;
`ifdef VRAM_CLEAR_EN
    localparam logic [1:0] S_CLEAR = 2'd2;
`endif

    logic [AddrWidth-1:0] fifo_addr [FifoDepth];
    logic [7:0]           fifo_data [FifoDepth];
    logic [PtrW-1:0]      wr_ptr;
    logic [PtrW-1:0]      rd_ptr;
    logic [PtrW:0]        count;

    logic [1:0]           state;
    logic                 ready_q;
    logic                 front_buf;
    logic [7:0]           drop_count;
    logic                 rd_p1;
    logic                 rd_p2;
    logic                 rd_valid;
    logic [7:0]           rd_data;
    logic [AddrWidth-1:0] mem_addr;
    logic [7:0]           mem_wdata;
    logic                 mem_we;
`ifdef VRAM_CLEAR_EN
    logic [AddrWidth-1:0] clr_addr;
`endif

    logic                 full;
    logic                 empty;
    logic                 in_range;
    logic                 accept;
    logic                 push;
    logic                 pop;
    logic                 clearing;
    logic                 swap_fire;
    logic                 wr_ready;
    logic [AddrWidth-1:0] back_base;
    logic [AddrWidth-1:0] front_base;
    logic [AddrWidth-1:0] lin_addr;

    always_comb begin
        full       = (count == (PtrW+1)'(FifoDepth));
        empty      = (count == '0);
        back_base  = front_buf ? '0 : FRAME_SIZE;
        front_base = front_buf ? FRAME_SIZE : '0;
`ifdef VRAM_CLEAR_EN
        clearing   = (state == S_CLEAR);
`else
        clearing   = 1'b0;
`endif
        // ready_q keeps WrReady low while in reset and releases it one edge later
        wr_ready   = ready_q && !full && (state != S_PEND) && !clearing;
        in_range   = (bus.WrX < 16'(HRes)) && (bus.WrY < 16'(VRes));
        lin_addr   = AddrWidth'(bus.WrY) * AddrWidth'(HRes) + AddrWidth'(bus.WrX);
        accept     = bus.WrValid && wr_ready;
        push       = accept && in_range;
        // Scanout has strict priority; the FIFO head simply waits
        pop        = !bus.RdReq && !empty;
        // Swapping only with an empty FIFO guarantees every earlier write
        // has already been issued against the old back buffer
        swap_fire  = (state == S_PEND) && bus.VBlank && empty && !pop;
    end

    always_ff @(posedge Clk) begin
        if (!ResetN) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            state      <= S_IDLE;
            ready_q    <= 1'b0;
            front_buf  <= 1'b0;
            drop_count <= '0;
            rd_p1      <= 1'b0;
            rd_p2      <= 1'b0;
            rd_valid   <= 1'b0;
            rd_data    <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_we     <= 1'b0;
`ifdef VRAM_CLEAR_EN
            clr_addr   <= '0;
`endif
        end else begin
            ready_q <= 1'b1;

            if (push) begin
                fifo_addr[wr_ptr] <= lin_addr;
                fifo_data[wr_ptr] <= bus.WrData;
                wr_ptr            <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            if (accept && !in_range && drop_count != 8'hFF) begin
                drop_count <= drop_count + 1'b1;
            end

            // Read pipeline: address out, RAM access, data capture
            rd_p1    <= bus.RdReq;
            rd_p2    <= rd_p1;
            rd_valid <= rd_p2;
            if (rd_p2) begin
                rd_data <= bus.MemRData;
            end

            mem_we <= 1'b0;
            if (bus.RdReq) begin
                mem_addr <= front_base + bus.RdAddr;
            end else if (pop) begin
                mem_addr  <= back_base + fifo_addr[rd_ptr];
                mem_wdata <= fifo_data[rd_ptr];
                mem_we    <= 1'b1;
            end
`ifdef VRAM_CLEAR_EN
            else if (clearing) begin
                mem_addr  <= back_base + clr_addr;
                mem_wdata <= ClearColor;
                mem_we    <= 1'b1;
            end
`endif

            case (state)
                S_IDLE: begin
                    if (bus.SwapReq) begin
                        state <= S_PEND;
                    end
                end
                S_PEND: begin
                    if (swap_fire) begin
                        front_buf <= !front_buf;
`ifdef VRAM_CLEAR_EN
                        clr_addr  <= '0;
                        state     <= S_CLEAR;
`else
                        state     <= S_IDLE;
`endif
                    end
                end
`ifdef VRAM_CLEAR_EN
                S_CLEAR: begin
                    if (!bus.RdReq) begin
                        clr_addr <= clr_addr + 1'b1;
                        if (clr_addr == FRAME_SIZE - 1'b1) begin
                            state <= S_IDLE;
                        end
                    end
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.WrReady     = wr_ready;
    assign bus.RdData      = rd_data;
    assign bus.RdValid     = rd_valid;
    assign bus.MemAddr     = mem_addr;
    assign bus.MemWData    = mem_wdata;
    assign bus.MemWe       = mem_we;
    assign bus.FrontBuf    = front_buf;
    assign bus.SwapPending = (state == S_PEND);
    assign bus.DropCount   = drop_count;
endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - self-checking bench for vram_arbiter
module tb_vram_arbiter;
    localparam int FS = 76800;

    typedef struct { int x; int y; logic [7:0] d; bit ok; int addr; } wvec_t;
    typedef struct { int addr; logic [7:0] data; } wexp_t;
    typedef struct { logic [7:0] data; int cyc; } rexp_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    vram_arbiter_if #(.AddrWidth(18)) bus ();
    vram_arbiter dut (.Clk(clk), .ResetN(resetn), .bus(bus));

    wexp_t wq[$];
    rexp_t rq[$];
    wexp_t we_item;
    rexp_t re_item;
    wvec_t tbl[7];
    int    checks = 0;
    int    fails = 0;
    int    cyc = 0;
    bit    model_front = 1'b0;
    int    exp_drop = 0;
    bit    clear_mode = 1'b0;
    int    clear_base = 0;
    int    clear_next = 0;
    bit    prev_rd = 1'b0;
    logic [7:0] ram [0:2*FS-1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_write(input int x, input int y, input logic [7:0] d);
        if (x >= 320 || y >= 240) begin
            if (exp_drop < 255) exp_drop++;
        end else begin
            wq.push_back('{(model_front ? 0 : FS) + y * 320 + x, d});
        end
    endtask

    task automatic do_write(input int x, input int y, input logic [7:0] d);
        int n = 0;
        bus.WrX = 16'(x);
        bus.WrY = 16'(y);
        bus.WrData = d;
        bus.WrValid = 1'b1;
        while (!bus.WrReady && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.WrReady) begin
            checks++; fails++;
            $display("FAIL write_ready_timeout: WrReady stayed 0, expected 1");
        end
        @(posedge clk); #1;
        bus.WrValid = 1'b0;
    endtask

    // Synchronous VRAM model, data valid one cycle after the address
    always @(posedge clk) begin
        if (bus.MemWe) ram[bus.MemAddr] <= bus.MemWData;
        bus.MemRData <= ram[bus.MemAddr];
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: pops expected writes on MemWe, expected reads on RdValid
    always @(negedge clk) begin
        if (resetn) begin
            if (prev_rd) check("no_write_after_read", 32'(bus.MemWe), 0);
            if (bus.MemWe) begin
                if (clear_mode) begin
                    check("clear_addr", 32'(bus.MemAddr), clear_base + clear_next);
                    check("clear_data", 32'(bus.MemWData), 0);
                    clear_next++;
                    if (clear_next == FS) clear_mode = 1'b0;
                end else if (wq.size() == 0) begin
                    checks++; fails++;
                    $display("FAIL unexpected_write: addr %0d data %0d, no write expected",
                             bus.MemAddr, bus.MemWData);
                end else begin
                    we_item = wq.pop_front();
                    check("wr_addr", 32'(bus.MemAddr), we_item.addr);
                    check("wr_data", 32'(bus.MemWData), 32'(we_item.data));
                end
            end
            if (bus.RdValid) begin
                if (rq.size() == 0) begin
                    checks++; fails++;
                    $display("FAIL unexpected_rdvalid: data %0d, no read expected", bus.RdData);
                end else begin
                    re_item = rq.pop_front();
                    check("rd_data", 32'(bus.RdData), 32'(re_item.data));
                    check("rd_latency", cyc - re_item.cyc, 3);
                end
            end
            if (bus.RdReq) rq.push_back('{ram[(model_front ? FS : 0) + int'(bus.RdAddr)], cyc});
        end
        prev_rd = resetn && bus.RdReq;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        for (int i = 0; i < 2 * FS; i++) ram[i] = 8'(i) ^ 8'h5A;
        tbl[0] = '{5, 2, 8'hA5, 1'b1, 77445};
        tbl[1] = '{0, 0, 8'h11, 1'b1, 76800};
        tbl[2] = '{319, 239, 8'h22, 1'b1, 153599};
        tbl[3] = '{320, 0, 8'h33, 1'b0, 0};
        tbl[4] = '{0, 240, 8'h44, 1'b0, 0};
        tbl[5] = '{319, 0, 8'h55, 1'b1, 77119};
        tbl[6] = '{0, 239, 8'h66, 1'b1, 153280};

        bus.WrValid = 0; bus.WrX = 0; bus.WrY = 0; bus.WrData = 0;
        bus.SwapReq = 0; bus.VBlank = 0; bus.RdReq = 0; bus.RdAddr = 0;

        // Reset values
        resetn = 1'b0;
        wait_cycles(3);
        check("rst_wr_ready", 32'(bus.WrReady), 0);
        check("rst_mem_we", 32'(bus.MemWe), 0);
        check("rst_mem_addr", 32'(bus.MemAddr), 0);
        check("rst_mem_wdata", 32'(bus.MemWData), 0);
        check("rst_rd_valid", 32'(bus.RdValid), 0);
        check("rst_rd_data", 32'(bus.RdData), 0);
        check("rst_front", 32'(bus.FrontBuf), 0);
        check("rst_pending", 32'(bus.SwapPending), 0);
        check("rst_drop", 32'(bus.DropCount), 0);
        resetn = 1'b1;
        wait_cycles(1);
        check("post_rst_wr_ready", 32'(bus.WrReady), 1);

        // Table-driven single writes, including range boundaries
        for (int i = 0; i < 7; i++) begin
            if (tbl[i].ok) wq.push_back('{tbl[i].addr, tbl[i].d});
            else exp_drop++;
            do_write(tbl[i].x, tbl[i].y, tbl[i].d);
            wait_cycles(2);
            check("tbl_drop", 32'(bus.DropCount), exp_drop);
            check("tbl_drained", wq.size(), 0);
            check("tbl_front", 32'(bus.FrontBuf), 0);
        end

        // Back-to-back reads
        bus.RdReq = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.RdAddr = 18'(10 + i);
            @(posedge clk); #1;
            check("rd_mem_addr", 32'(bus.MemAddr), 10 + i);
            check("rd_mem_we", 32'(bus.MemWe), 0);
        end
        bus.RdReq = 1'b0;
        wait_cycles(5);
        check("rd_drained", rq.size(), 0);

        // Fill FIFO under continuous reads
        bus.RdReq = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.RdAddr = 18'(100 + i);
            check("fifo_wr_ready", 32'(bus.WrReady), (i < 4) ? 1 : 0);
            bus.WrX = 16'(10 + i); bus.WrY = 16'd3; bus.WrData = 8'(8'hC0 + i);
            bus.WrValid = 1'b1;
            if (i < 4) wq.push_back('{FS + 3 * 320 + 10 + i, 8'(8'hC0 + i)});
            @(posedge clk); #1;
        end
        bus.WrValid = 1'b0;
        check("fifo_held", wq.size(), 4);
        bus.RdReq = 1'b0;
        wait_cycles(6);
        check("fifo_drained", wq.size(), 0);
        check("fifo_rd_drained", rq.size(), 0);

        // Out-of-range writes and saturation
        expect_write(320, 0, 8'h01);
        do_write(320, 0, 8'h01);
        wait_cycles(1);
        check("drop_one", 32'(bus.DropCount), exp_drop);
        for (int i = 0; i < 300; i++) begin
            expect_write(1000 + i, 5, 8'(i));
            do_write(1000 + i, 5, 8'(i));
        end
        wait_cycles(2);
        check("drop_saturate", 32'(bus.DropCount), 255);

        // Swap with queued writes, VBlank arriving after the drain
        bus.RdReq = 1'b1; bus.RdAddr = 0;
        expect_write(1, 1, 8'h5B); do_write(1, 1, 8'h5B);
        expect_write(2, 1, 8'h5C); do_write(2, 1, 8'h5C);
        bus.SwapReq = 1'b1;
        @(posedge clk); #1;
        bus.SwapReq = 1'b0;
        check("swap_pending", 32'(bus.SwapPending), 1);
        check("swap_wr_ready", 32'(bus.WrReady), 0);
        check("swap_front_hold", 32'(bus.FrontBuf), 0);
        bus.RdReq = 1'b0;
        wait_cycles(4);
        check("swap_fifo_drained", wq.size(), 0);
        check("swap_waits_vblank", 32'(bus.FrontBuf), 0);
        check("swap_still_pending", 32'(bus.SwapPending), 1);
`ifdef VRAM_CLEAR_EN
        clear_base = 0; clear_next = 0; clear_mode = 1'b1;
`endif
        bus.VBlank = 1'b1;
        n = 0;
        while (bus.FrontBuf !== 1'b1 && n < 10) begin @(posedge clk); #1; n++; end
        check("swap_front_toggle", 32'(bus.FrontBuf), 1);
        model_front = 1'b1;
        bus.VBlank = 1'b0;
        check("swap_done", 32'(bus.SwapPending), 0);
        n = 0;
        while (!bus.WrReady && n < 80000) begin @(posedge clk); #1; n++; end
        check("ready_after_swap", 32'(bus.WrReady), 1);
`ifdef VRAM_CLEAR_EN
        check("clear_count", clear_next, FS);
`endif
        expect_write(5, 2, 8'h3C);
        do_write(5, 2, 8'h3C);
        wait_cycles(3);
        check("post_swap_drained", wq.size(), 0);
        rq.delete();

        // Reset with reads in flight, writes queued and a swap pending
        bus.RdReq = 1'b1; bus.RdAddr = 18'd5;
        do_write(7, 7, 8'h77);
        do_write(8, 7, 8'h78);
        bus.SwapReq = 1'b1;
        @(posedge clk); #1;
        bus.SwapReq = 1'b0;
`ifdef VRAM_CLEAR_EN
        wq.push_back('{7 * 320 + 7, 8'h77});
        wq.push_back('{7 * 320 + 8, 8'h78});
        clear_base = FS; clear_next = 0; clear_mode = 1'b1;
        bus.RdReq = 1'b0; bus.VBlank = 1'b1;
        n = 0;
        while (bus.FrontBuf !== 1'b0 && n < 20) begin @(posedge clk); #1; n++; end
        wait_cycles(20);
        check("mid_clear_ready", 32'(bus.WrReady), 0);
`endif
        resetn = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_mem_we", 32'(bus.MemWe), 0);
        check("mid_rst_mem_addr", 32'(bus.MemAddr), 0);
        check("mid_rst_mem_wdata", 32'(bus.MemWData), 0);
        check("mid_rst_rd_valid", 32'(bus.RdValid), 0);
        check("mid_rst_rd_data", 32'(bus.RdData), 0);
        check("mid_rst_front", 32'(bus.FrontBuf), 0);
        check("mid_rst_pending", 32'(bus.SwapPending), 0);
        check("mid_rst_drop", 32'(bus.DropCount), 0);
        check("mid_rst_wr_ready", 32'(bus.WrReady), 0);
        clear_mode = 1'b0;
        wq.delete(); rq.delete();
        model_front = 1'b0;
        bus.RdReq = 1'b0; bus.VBlank = 1'b0;
        resetn = 1'b1;
        wait_cycles(1);
        check("mid_post_rst_ready", 32'(bus.WrReady), 1);
        wait_cycles(6);
        check("mid_post_rst_front", 32'(bus.FrontBuf), 0);
        check("mid_post_rst_rdvalid", 32'(bus.RdValid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Owns the single-port video RAM.
- Shares the RAM between the scanout reader (strict priority) and the pixel-write stream from the command decoder: SetX/SetY position plus WriteNP bytes.
- Translates (X,Y) to a linear address in the back buffer, buffers writes in a small FIFO, and executes BufSwap at vertical blank.
- Sits between the command decoder, the VGA timing/scanout block and the VRAM primitive.

Parameters:
- HRes, 320, visible pixels per line.
- VRes, 240, visible lines per frame.
- AddrWidth, 18, VRAM address width; 2*HRes*VRes <= 2^AddrWidth is required.
- FifoDepth, 4, write FIFO entries (power of 2, >=2).
- ClearColor, 8'h00, fill value for the optional clear engine.

Ports:
- Clk  in  1  system clock; all logic on its rising edge.
- ResetN  in  1  synchronous active-low reset.
- WrValid  in  1  write request from the command decoder.
- WrReady  out  1  FIFO can accept a write; transfer occurs when WrValid&&WrReady.
- WrX  in  16  pixel X.
- WrY  in  16  pixel Y.
- WrData  in  8  pixel value.
- SwapReq  in  1  one-cycle pulse requesting a buffer swap.
- VBlank  in  1  high during vertical blank, from the timing block.
- RdReq  in  1  scanout read request.
- RdAddr  in  AddrWidth  offset within the front frame (0..HRes*VRes-1).
- RdData  out  8  scanout pixel.
- RdValid  out  1  RdData valid, 1-cycle pulse.
- MemAddr  out  AddrWidth  VRAM address (registered).
- MemWData  out  8  VRAM write data (registered).
- MemWe  out  1  VRAM write enable (registered).
- MemRData  in  8  VRAM read data; synchronous RAM, valid 1 cycle after address.
- FrontBuf  out  1  buffer currently displayed (0: base 0, 1: base HRes*VRes).
- SwapPending  out  1  swap requested, not yet executed.
- DropCount  out  8  saturating count of out-of-range writes.

Behaviour:
- Reset (ResetN=0 at a rising edge): FIFO emptied; all in-flight ops cancelled; MemWe=0, MemAddr=0, MemWData=0, RdValid=0, RdData=0, FrontBuf=0, SwapPending=0, DropCount=0. WrReady=0 during reset, 1 the first cycle after.
- FrameSize = HRes*VRes. BackBase = FrontBuf ? 0 : FrameSize. FrontBase is the other buffer. Address arithmetic is AddrWidth wide, no wrap.
- Push: on WrValid&&WrReady, if WrX>=HRes or WrY>=VRes, the entry is discarded and DropCount increments (saturates at 255). Otherwise {WrY*HRes+WrX, WrData} is pushed. The address is computed at push time in the same cycle, with no base added.
- WrReady = !full && !SwapPending (&& !Clearing under the option). Simultaneous push and pop when full is not allowed, since WrReady is low when full.
- Arbitration, one VRAM access per cycle:
  - RdReq=1 in cycle N: cycle N+1 drives MemAddr=FrontBase+RdAddr, MemWe=0. Cycle N+2 latches MemRData; cycle N+3 RdData valid with RdValid=1. Fixed 3-cycle latency, back-to-back reads every cycle supported.
  - RdReq=0 and FIFO not empty in cycle N: pop. Cycle N+1 drives MemAddr=BackBase+entry address, MemWData=data, MemWe=1 for exactly one cycle.
  - Both in cycle N: the read wins; the FIFO head waits, with no loss and order preserved.
- Swap FSM states:
  - IDLE: SwapReq -> PEND, SwapPending=1.
  - PEND: waits for VBlank=1 && FIFO empty && no write issued in the current cycle, then toggles FrontBuf -> IDLE, or -> CLEAR under the option. SwapReq in PEND is ignored.
  - If VBlank falls before the FIFO drains, the swap waits for the next VBlank.
- Write order is preserved; every write pushed before SwapReq lands in the pre-swap back buffer.

Optional Feature:
- VRAM_CLEAR_EN defined: after the swap toggles FrontBuf, the FSM enters CLEAR.
  - CLEAR writes ClearColor to BackBase+0 .. BackBase+FrameSize-1, one address per cycle whenever RdReq=0 (reads keep priority).
  - Clearing=1 and WrReady=0 until the last address is written, then -> IDLE.
  - Reset mid-clear aborts it.
- VRAM_CLEAR_EN undefined: no CLEAR state; the back buffer keeps stale contents; WrReady is independent of clearing.

Test Plan:
- Reset, then write X=5, Y=2, D=8'hA5 with RdReq=0 -> one cycle later MemWe=1, MemAddr=FrameSize+645=77445, MemWData=8'hA5; FrontBuf=0.
- RdReq held 1 for 3 cycles, RdAddr=10,11,12, FrontBuf=0 -> MemAddr=10,11,12 with MemWe=0; RdValid high on cycles 3..5 carrying the preloaded RAM data.
- FIFO of 4 writes pushed while RdReq=1 for 6 cycles -> WrReady drops after 4 pushes; zero writes during reads; 4 writes in push order after RdReq falls.
- Write X=320, Y=0 -> no push, no MemWe, DropCount=1; 300 bad writes -> DropCount=255.
- 2 writes queued, SwapReq, VBlank=1 -> SwapPending=1, WrReady=0; both writes reach base 76800; FrontBuf toggles to 1 only after the FIFO is empty; next write targets base 0.
- VRAM_CLEAR_EN: swap -> 76800 MemWe cycles of ClearColor over 0..76799 (FrontBuf=1), stretched by interleaved reads; WrReady=0 until done. ResetN=0 mid-clear -> all outputs at reset values the next cycle.
